// File: rtl/ws_weight_loader_pkg.sv
// Shared types and sizing for the weight-stationary tile loader.
package ws_weight_loader_pkg;
  localparam int A_H_DEF   = 16;
  localparam int B_W_DEF   = 16;
  localparam int WIDTH_DEF = 8;
  localparam int ROW_W     = A_H_DEF * WIDTH_DEF;
  localparam int CNT_W     = $clog2(B_W_DEF + 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    TAIL = 2'd2
  } state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/ws_weight_buf.sv
// Tile row storage: one synchronous write port, one combinational read port.
module ws_weight_buf #(
  parameter int DEPTH = 16,
  parameter int ROW_W = 128,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [ROW_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [ROW_W-1:0] rd_data
);
  logic [ROW_W-1:0] mem_q [DEPTH];

  // contents are deliberately left unreset; every row is rewritten before use
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/ws_weight_loader.sv
// Buffers a B_W-row weight tile from a valid/ready stream, then shifts it
// into the MAC array deepest column first.
module ws_weight_loader
  import ws_weight_loader_pkg::*;
#(
  parameter int A_H   = A_H_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [A_H*WIDTH-1:0] s_data,
  output logic                 weight_wen,
  output logic [A_H*WIDTH-1:0] weight_din,
  output logic                 busy,
  output logic                 load_done
);
  localparam int RW = A_H * WIDTH;
  localparam int CW = $clog2(B_W + 1);
  localparam int AW = addr_w(B_W);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   din_q, din_d;
  logic            s_ready_q, busy_q, wen_q, done_q;
  logic            hs, last;
  logic            wr_en;
  logic [AW-1:0]   rd_addr;
  logic [RW-1:0]   rd_data;

  assign hs      = s_valid && s_ready_q;
  assign last    = (cnt_q == CW'(B_W - 1));
  // prefetch the row for the next LOAD cycle: Lk+1 shows row B_W-2-k
  assign rd_addr = AW'(B_W - 2) - cnt_q[AW-1:0];

  ws_weight_buf #(.DEPTH(B_W), .ROW_W(RW), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt_q[AW-1:0]),
    .wr_data (s_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = '0;
    wr_en   = 1'b0;
    case (state_q)
      FILL: begin
        if (hs) begin
          wr_en = 1'b1;
          if (last) begin
            state_d = LOAD;
            cnt_d   = '0;
            // the final row is still being written, so forward it directly
            din_d   = s_data;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD: begin
        if (last) begin
          state_d = TAIL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          din_d = rd_data;
        end
      end
      TAIL:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // wen trails din by one cycle since the array registers din but not wen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      din_q     <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      s_ready_q <= (state_d == FILL);
      busy_q    <= (state_d != FILL);
      wen_q     <= (state_q == LOAD);
      done_q    <= (state_q == TAIL);
    end
  end

  assign s_ready    = s_ready_q;
  assign weight_wen = wen_q;
  assign weight_din = din_q;
  assign busy       = busy_q;
  assign load_done  = done_q;
endmodule

// File: tb/tb_ws_weight_loader.sv
// Scoreboard bench for ws_weight_loader: tile rows go in, reversed rows are
// expected on weight_din one cycle ahead of each weight_wen.
module tb_ws_weight_loader;
  localparam int A_H   = 16;
  localparam int B_W   = 16;
  localparam int WIDTH = 8;
  localparam int RW    = A_H * WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [RW-1:0] s_data;
  logic          weight_wen;
  logic [RW-1:0] weight_din;
  logic          busy;
  logic          load_done;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] prev_din = '0;
  logic [RW-1:0] sb_exp;
  logic [RW-1:0] tile [B_W];

  ws_weight_loader #(.A_H(A_H), .B_W(B_W), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .weight_wen (weight_wen),
    .weight_din (weight_din),
    .busy       (busy),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // each wen cycle must present the row that weight_din held one cycle earlier
  always @(negedge clk) begin
    if (weight_wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_wen got din=%h with no row expected", prev_din);
      end else begin
        sb_exp = exp_q.pop_front();
        if (prev_din !== sb_exp) begin
          errors++;
          $display("FAIL sb_row got %h exp %h", prev_din, sb_exp);
        end
      end
    end
    prev_din = weight_din;
  end

  function automatic logic [RW-1:0] row_of(input logic [7:0] b);
    return {A_H{b}};
  endfunction

  task automatic send_row(input logic [RW-1:0] d);
    logic rdy;
    int   n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    do begin
      rdy = s_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout row %h never accepted", d);
    end
  endtask

  task automatic send_tile(input logic [7:0] base, input int first, input int stop, input bit gapped);
    for (int k = first; k < stop; k++) begin
      tile[k] = row_of(base + 8'(k));
      if (gapped && k > first) begin
        s_valid = 1'b0;
        s_data  = {A_H/4{$urandom()}};
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || weight_wen !== 1'b0) begin
          errors++;
          $display("FAIL gap_idle row %0d busy=%b wen=%b exp 0 0", k, busy, weight_wen);
        end
      end
      send_row(tile[k]);
    end
  endtask

  task automatic push_tile();
    for (int k = B_W - 1; k >= 0; k--) exp_q.push_back(tile[k]);
  endtask

  // entered at the negedge of cycle T+1, where T holds the last handshake
  task automatic check_window(input string tag);
    logic          e_busy, e_wen, e_done, e_rdy;
    logic [RW-1:0] e_din;
    for (int i = 1; i <= B_W + 2; i++) begin
      e_busy = (i <= B_W + 1);
      e_wen  = (i >= 2 && i <= B_W + 1);
      e_din  = (i <= B_W) ? tile[B_W - i] : '0;
      e_done = (i == B_W + 2);
      e_rdy  = (i == B_W + 2);
      checks++;
      if ({busy, weight_wen, load_done, s_ready, weight_din} !== {e_busy, e_wen, e_done, e_rdy, e_din}) begin
        errors++;
        $display("FAIL %s T+%0d got busy=%b wen=%b done=%b rdy=%b din=%h exp %b %b %b %b %h",
                 tag, i, busy, weight_wen, load_done, s_ready, weight_din,
                 e_busy, e_wen, e_done, e_rdy, e_din);
      end
      if (i < B_W + 2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({s_ready, weight_wen, busy, load_done, weight_din} !== '0) begin
        errors++;
        $display("FAIL reset_outputs rdy=%b wen=%b busy=%b done=%b din=%h exp all 0",
                 s_ready, weight_wen, busy, load_done, weight_din);
      end
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", s_ready);
    end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({weight_wen, busy, load_done, s_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL idle got wen=%b busy=%b done=%b rdy=%b exp 0 0 0 1",
                 weight_wen, busy, load_done, s_ready);
      end
    end
  endtask

  task automatic test_full_tile();
    send_tile(8'h01, 0, B_W, 1'b0);
    s_valid = 1'b0;
    push_tile();
    check_window("full_tile");
    @(negedge clk);
  endtask

  task automatic test_gapped();
    send_tile(8'h11, 0, B_W, 1'b1);
    s_valid = 1'b0;
    push_tile();
    check_window("gapped");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    send_tile(8'h31, 0, B_W, 1'b0);
    push_tile();
    s_valid = 1'b1;
    s_data  = row_of(8'hAA);
    check_window("backpressure");
    tile[0] = row_of(8'hAA);
    @(negedge clk);
    send_tile(8'h40, 1, B_W, 1'b0);
    s_valid = 1'b0;
    push_tile();
    check_window("after_bp");
    @(negedge clk);
  endtask

  task automatic test_partial();
    send_tile(8'h61, 0, B_W - 1, 1'b0);
    s_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      checks++;
      if ({busy, weight_wen, s_ready} !== 3'b001) begin
        errors++;
        $display("FAIL partial_wait got busy=%b wen=%b rdy=%b exp 0 0 1", busy, weight_wen, s_ready);
      end
    end
    send_tile(8'h61, B_W - 1, B_W, 1'b0);
    s_valid = 1'b0;
    push_tile();
    check_window("partial");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    send_tile(8'h81, 0, B_W, 1'b0);
    s_valid = 1'b0;
    push_tile();
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, weight_wen} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_L5 got busy=%b wen=%b exp 1 1", busy, weight_wen);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, weight_wen, busy, load_done, weight_din} !== '0) begin
      errors++;
      $display("FAIL async_reset rdy=%b wen=%b busy=%b done=%b din=%h exp all 0",
               s_ready, weight_wen, busy, load_done, weight_din);
    end
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, busy, weight_wen} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset got rdy=%b busy=%b wen=%b exp 1 0 0", s_ready, busy, weight_wen);
    end
    send_tile(8'h91, 0, B_W, 1'b0);
    s_valid = 1'b0;
    push_tile();
    check_window("reload");
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_tile();
    test_gapped();
    test_back_to_back();
    test_partial();
    test_reset_mid_load();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d rows left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
